spectrogram_sink: RTL

//  Terminal consumer of the magnitude stream leaving the FFT top (tdata/tlast, valid/ready).

---
 rtl/spectrogram_sink.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/spectrogram_sink.sv
// Terminal sink for the FFT magnitude stream: stores NFRAMES x NBINS framed spectra in RAM and then
// serves them through a random-access read port. Optional peak tracker under SPECTROGRAM_SINK_PEAK_EN.
module spectrogram_sink #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned NBINS   = 257,
  parameter int unsigned NFRAMES = 97
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [DATA_W-1:0]            s_tdata,
  input  logic                         s_tlast,
  input  logic                         s_tvalid,
  output logic                         s_tready,
  input  logic                         rd_en,
  input  logic [$clog2(NFRAMES)-1:0]   rd_frame,
  input  logic [$clog2(NBINS)-1:0]     rd_bin,
  output logic [DATA_W-1:0]            rd_data,
  output logic                         rd_valid,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(NFRAMES+1)-1:0] frame_cnt,
  output logic                         err_frame
`ifdef SPECTROGRAM_SINK_PEAK_EN
  ,
  output logic [$clog2(NBINS)-1:0]     pk_bin,
  output logic [DATA_W-1:0]            pk_val,
  output logic                         pk_valid
`endif
);

  localparam int unsigned BW    = $clog2(NBINS);
  localparam int unsigned CW    = $clog2(NFRAMES + 1);
  localparam int unsigned DEPTH = NBINS * NFRAMES;
  localparam int unsigned AW    = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t            r_state;
  logic              r_busy;
  logic              r_done;
  logic              r_in_frame;
  logic              r_resync;
  logic              r_err;
  logic [BW-1:0]     r_bin;
  logic [AW-1:0]     r_base;
  logic [CW-1:0]     r_frame_cnt;

  logic              r_rd_v1;
  logic              r_rd_oor1;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;
  logic [DATA_W-1:0] r_ram_q;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_beat;
  logic              w_store;
  logic              w_bin_last;
  logic              w_frame_ok;
  logic              w_arm_start;
  logic              w_rd_fire;
  logic              w_rd_oor;
  logic [AW-1:0]     w_waddr;
  logic [AW-1:0]     w_raddr;

  assign s_tready    = 1'b1;
  assign w_beat      = s_tvalid && s_tready;
  assign w_store     = (r_state == S_CAPTURE) && w_beat && !r_resync;
  assign w_bin_last  = (r_bin == BW'(NBINS - 1));
  assign w_frame_ok  = w_store && s_tlast && w_bin_last;
  // A beat in flight (or an unfinished frame) means we must wait for the next frame boundary.
  assign w_arm_start = r_in_frame || w_beat;
  assign w_waddr     = r_base + AW'(r_bin);

  assign w_rd_fire   = rd_en && (r_state == S_DONE);
  assign w_rd_oor    = (32'(rd_frame) >= NFRAMES) || (32'(rd_bin) >= NBINS);
  assign w_raddr     = w_rd_oor ? '0 : (AW'(rd_frame) * AW'(NBINS) + AW'(rd_bin));

  assign busy      = r_busy;
  assign done      = r_done;
  assign frame_cnt = r_frame_cnt;
  assign err_frame = r_err;
  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;

  // Capture control: framing check, slot/bin bookkeeping and state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_in_frame  <= 1'b0;
      r_resync    <= 1'b0;
      r_err       <= 1'b0;
      r_bin       <= '0;
      r_base      <= '0;
      r_frame_cnt <= '0;
    end else begin
      if (w_beat) r_in_frame <= !s_tlast;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_frame_cnt <= '0;
            r_err       <= 1'b0;
            r_bin       <= '0;
            r_base      <= '0;
            r_resync    <= 1'b0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_state     <= w_arm_start ? S_ARMED : S_CAPTURE;
          end
        end
        S_ARMED: begin
          if (w_beat && s_tlast) r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          if (w_beat) begin
            if (r_resync) begin
              if (s_tlast) r_resync <= 1'b0;
            end else if (s_tlast) begin
              r_bin <= '0;
              if (w_frame_ok) begin
                r_frame_cnt <= r_frame_cnt + CW'(1);
                r_base      <= r_base + AW'(NBINS);
                if (r_frame_cnt == CW'(NFRAMES - 1)) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                end
              end else begin
                r_err <= 1'b1;
              end
            end else if (w_bin_last) begin
              // Overlong frame: discard the slot contents and skip to the next tlast.
              r_bin    <= '0;
              r_err    <= 1'b1;
              r_resync <= 1'b1;
            end else begin
              r_bin <= r_bin + BW'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Spectrogram RAM; contents survive rst.
  always_ff @(posedge clk) begin
    if (w_store) r_mem[w_waddr] <= s_tdata;
    if (w_rd_fire) r_ram_q <= r_mem[w_raddr];
  end

  // Read pipeline: RAM stage then output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_v1    <= 1'b0;
      r_rd_oor1  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_v1    <= w_rd_fire;
      r_rd_oor1  <= w_rd_oor;
      r_rd_valid <= r_rd_v1;
      if (r_rd_v1) r_rd_data <= r_rd_oor1 ? '0 : r_ram_q;
    end
  end

`ifdef SPECTROGRAM_SINK_PEAK_EN
  logic [DATA_W-1:0] r_pk_max;
  logic [BW-1:0]     r_pk_idx;
  logic [BW-1:0]     r_pk_bin;
  logic [DATA_W-1:0] r_pk_val;
  logic              r_pk_valid;
  logic              w_pk_take;

  // Strictly-greater keeps the lowest bin on ties; bin 0 restarts the search.
  assign w_pk_take = (r_bin == '0) || (s_tdata > r_pk_max);
  assign pk_bin    = r_pk_bin;
  assign pk_val    = r_pk_val;
  assign pk_valid  = r_pk_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pk_max   <= '0;
      r_pk_idx   <= '0;
      r_pk_bin   <= '0;
      r_pk_val   <= '0;
      r_pk_valid <= 1'b0;
    end else begin
      r_pk_valid <= 1'b0;
      if (w_store) begin
        if (w_pk_take) begin
          r_pk_max <= s_tdata;
          r_pk_idx <= r_bin;
        end
        if (w_frame_ok) begin
          r_pk_valid <= 1'b1;
          r_pk_val   <= w_pk_take ? s_tdata : r_pk_max;
          r_pk_bin   <= w_pk_take ? r_bin : r_pk_idx;
        end
      end
    end
  end
`endif

endmodule
